// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two-channel pushbutton synchroniser, debouncer and press-pulse generator
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic P1,
  output logic P2,
  output logic lvl1,
  output logic lvl2
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    HELD   = 2'd2,
    DISARM = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0] raw;
  logic [1:0] sync_a_q;
  logic [1:0] sync_b_q;
  logic [1:0] pulse_w;
  logic [1:0] lvl_w;

  assign raw = {btn2_raw, btn1_raw};

  // Two-flop synchroniser per channel; only sync_b_q is seen by the FSMs
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_a_q <= 2'b00;
      sync_b_q <= 2'b00;
    end else begin
      sync_a_q <= raw;
      sync_b_q <= sync_a_q;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q;
    logic             lvl_q;
    logic             s;

    assign s = sync_b_q[ch];

    // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
    // identical samples; the press pulse and level are registered with the state
    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
        lvl_q   <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (s) begin
              state_q <= ARM;
              cnt_q   <= CNT_ONE;
            end
          end
          ARM: begin
            if (!s) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= HELD;
              cnt_q   <= '0;
              pulse_q <= 1'b1;
              lvl_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          HELD: begin
            if (!s) begin
              state_q <= DISARM;
              cnt_q   <= CNT_ONE;
            end
          end
          DISARM: begin
            if (s) begin
              state_q <= HELD;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              lvl_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
          end
        endcase
      end
    end

    assign pulse_w[ch] = pulse_q;
    assign lvl_w[ch]   = lvl_q;
  end

  assign P1   = pulse_w[0];
  assign P2   = pulse_w[1];
  assign lvl1 = lvl_w[0];
  assign lvl2 = lvl_w[1];

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

  logic clk;
  logic reset;
  logic btn1_raw;
  logic btn2_raw;
  logic P1;
  logic P2;
  logic lvl1;
  logic lvl2;

  int total;
  int bad;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn1_raw(btn1_raw),
    .btn2_raw(btn2_raw),
    .P1(P1),
    .P2(P2),
    .lvl1(lvl1),
    .lvl2(lvl2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge; inputs set after this return are sampled at the next edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;
    step();
    step();
    total++;
    if ({P1, P2, lvl1, lvl2} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0000", {P1, P2, lvl1, lvl2});
    end
    reset = 1'b1;
    step();
    total++;
    if ({P1, P2, lvl1, lvl2} !== 4'b0000) begin
      bad++;
      $display("FAIL post_reset_idle got=%b want=0000", {P1, P2, lvl1, lvl2});
    end
  endtask

  task automatic test_press_release();
    btn1_raw = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      step();
      total++;
      if (P1 !== (i == 5)) begin
        bad++;
        $display("FAIL press_p1 edge=E0+%0d got=%b want=%b", i, P1, (i == 5));
      end
      total++;
      if (lvl1 !== (i >= 5)) begin
        bad++;
        $display("FAIL press_lvl1 edge=E0+%0d got=%b want=%b", i, lvl1, (i >= 5));
      end
      total++;
      if ({P2, lvl2} !== 2'b00) begin
        bad++;
        $display("FAIL press_ch2_quiet edge=E0+%0d got=%b want=00", i, {P2, lvl2});
      end
    end
    btn1_raw = 1'b0;
    for (int i = 0; i <= 9; i++) begin
      step();
      total++;
      if (lvl1 !== (i < 5)) begin
        bad++;
        $display("FAIL release_lvl1 edge=E0+%0d got=%b want=%b", i, lvl1, (i < 5));
      end
      total++;
      if (P1 !== 1'b0) begin
        bad++;
        $display("FAIL release_no_pulse edge=E0+%0d got=%b want=0", i, P1);
      end
    end
  endtask

  task automatic test_bounce();
    int pulses;
    logic [3:0] pattern;
    pattern = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      btn1_raw = pattern[i];
      step();
      total++;
      if ({P1, lvl1} !== 2'b00) begin
        bad++;
        $display("FAIL bounce_reject cyc=%0d got=%b want=00", i, {P1, lvl1});
      end
    end
    btn1_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if ({P1, lvl1} !== 2'b00) begin
        bad++;
        $display("FAIL bounce_settle cyc=%0d got=%b want=00", i, {P1, lvl1});
      end
    end
    pulses = 0;
    btn1_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (P1 === 1'b1) pulses++;
      total++;
      if (P1 !== (i == 5)) begin
        bad++;
        $display("FAIL bounce_then_hold_p1 edge=E0+%0d got=%b want=%b", i, P1, (i == 5));
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL bounce_pulse_count got=%0d want=1", pulses);
    end
    btn1_raw = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_release_glitch();
    btn2_raw = 1'b1;
    for (int i = 0; i < 8; i++) step();
    total++;
    if (lvl2 !== 1'b1) begin
      bad++;
      $display("FAIL glitch_held_lvl2 got=%b want=1", lvl2);
    end
    btn2_raw = 1'b0;
    step();
    step();
    btn2_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if ({P2, lvl2} !== 2'b01) begin
        bad++;
        $display("FAIL glitch_keep cyc=%0d got=%b want=01", i, {P2, lvl2});
      end
    end
    btn2_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (lvl2 !== (i < 5)) begin
        bad++;
        $display("FAIL glitch_release_lvl2 edge=E0+%0d got=%b want=%b", i, lvl2, (i < 5));
      end
      total++;
      if (P2 !== 1'b0) begin
        bad++;
        $display("FAIL glitch_release_no_pulse edge=E0+%0d got=%b want=0", i, P2);
      end
    end
  endtask

  task automatic test_simultaneous();
    btn1_raw = 1'b1;
    btn2_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if ({P1, P2} !== ((i == 5) ? 2'b11 : 2'b00)) begin
        bad++;
        $display("FAIL simul_pulses edge=E0+%0d got=%b want=%b", i, {P1, P2},
                 ((i == 5) ? 2'b11 : 2'b00));
      end
    end
    total++;
    if ({lvl1, lvl2} !== 2'b11) begin
      bad++;
      $display("FAIL simul_levels got=%b want=11", {lvl1, lvl2});
    end
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_reset_mid();
    int pulses;
    btn1_raw = 1'b1;
    step();
    step();
    total++;
    if (P1 !== 1'b0) begin
      bad++;
      $display("FAIL midreset_arm_no_pulse got=%b want=0", P1);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++;
    if ({P1, lvl1} !== 2'b00) begin
      bad++;
      $display("FAIL midreset_cleared got=%b want=00", {P1, lvl1});
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (P1 === 1'b1) pulses++;
      total++;
      if (P1 !== (i == 5)) begin
        bad++;
        $display("FAIL midreset_repress_p1 edge=E0+%0d got=%b want=%b", i, P1, (i == 5));
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL midreset_pulse_count got=%0d want=1", pulses);
    end
    btn1_raw = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_back_to_back();
    int p1_cnt;
    int p2_cnt;
    p1_cnt = 0;
    p2_cnt = 0;
    for (int c = 0; c < 48; c++) begin
      btn1_raw = ((c < 8) || (c >= 32 && c < 40));
      btn2_raw = (c >= 16 && c < 24);
      step();
      if (P1 === 1'b1) p1_cnt++;
      if (P2 === 1'b1) p2_cnt++;
      total++;
      if (P1 !== (c == 5 || c == 37)) begin
        bad++;
        $display("FAIL b2b_p1 cyc=%0d got=%b want=%b", c, P1, (c == 5 || c == 37));
      end
      total++;
      if (P2 !== (c == 21)) begin
        bad++;
        $display("FAIL b2b_p2 cyc=%0d got=%b want=%b", c, P2, (c == 21));
      end
    end
    total++;
    if (p1_cnt != 2) begin
      bad++;
      $display("FAIL b2b_p1_count got=%0d want=2", p1_cnt);
    end
    total++;
    if (p2_cnt != 1) begin
      bad++;
      $display("FAIL b2b_p2_count got=%0d want=1", p2_cnt);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;
    test_reset();
    test_press_release();
    test_bounce();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Two-channel pushbutton front end.
- Takes raw, asynchronous, bouncing button inputs and synchronises and debounces them.
- Emits one-clock press pulses on P1/P2, which drive the P1/P2 inputs of the Moore sequence FSM directly downstream.
- Also exports the debounced levels for LEDs and diagnostics.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive identical synchronised samples required to accept a level change. Minimum 2; set to 1_000_000 for board builds.
- CNT_W, 20, width of each debounce counter. DEBOUNCE_CYCLES must be less than 2^CNT_W.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- btn1_raw  input  1  raw button 1, asynchronous to clk, may bounce.
- btn2_raw  input  1  raw button 2, asynchronous to clk, may bounce.
- P1  output  1  one-clock pulse on each accepted press of button 1; registered.
- P2  output  1  one-clock pulse on each accepted press of button 2; registered.
- lvl1  output  1  debounced level of button 1; registered.
- lvl2  output  1  debounced level of button 2; registered.

Behaviour:
- Reset (reset==0 at posedge):
  - Both 2-flop synchronisers, both FSMs and both counters clear: state IDLE, cnt=0.
  - P1=P2=lvl1=lvl2=0 on the next cycle.
  - Reset overrides all other activity.
- Synchroniser, per channel: raw -> sync_a -> sync_b. Let s = sync_b. s is the only signal the FSM uses.
- Channel FSM, per channel, fully independent:
  - IDLE (lvl=0): s=1 -> ARM, cnt=1. Otherwise stay.
  - ARM (lvl=0):
    - s=0 -> IDLE, cnt=0; bounce rejected, no pulse.
    - s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, pulse=1 for exactly this one cycle.
    - Else cnt++.
  - HELD (lvl=1): s=0 -> DISARM, cnt=1. Otherwise stay; pulse=0.
  - DISARM (lvl=1):
    - s=1 -> HELD, cnt=0; release bounce rejected.
    - s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, lvl=0.
    - Else cnt++.
- lvl is 1 exactly in HELD and DISARM, registered with the state.
- Press latency:
  - raw first sampled high at posedge E0 and held.
  - P pulse is high in the cycle after edge E0+DEBOUNCE_CYCLES+1 and low again after the following edge.
  - lvl rises on the same edge as P.
- Release latency: symmetric. lvl falls after edge E0+DEBOUNCE_CYCLES+1 from the first low sample. No pulse on release.
- Holding a button produces exactly one pulse, however long it is held. The next pulse requires a full release (return to IDLE) and a new press.
- Simultaneous events:
  - Channels never interact.
  - If both channels qualify on the same edge, P1 and P2 are both high in the same cycle. The downstream FSM defines the meaning of that.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset mid-operation:
  - Reset in ARM aborts the press with no pulse.
  - Reset in HELD drops lvl with no pulse.
  - A button still held when reset releases is treated as a fresh press: pulse after the full latency from the first post-reset sample.

Test Plan (DEBOUNCE_CYCLES=4, clk period 10 ns):
- Reset for 2 cycles, then btn1_raw=1 sampled at edge E0 and held 20 cycles -> P1 high only in the cycle after edge E0+5; lvl1=1 from that edge onward. P2=lvl2=0 throughout.
- btn1_raw toggled 1,0,1,0 on successive cycles, then held 0 -> no P1 pulse; lvl1 stays 0. Then held 1 for 6+ cycles -> exactly one P1 pulse.
- Hold btn2 pressed (lvl2=1), glitch btn2_raw low for 2 cycles, hold high -> lvl2 stays 1, no P2 pulse. Release for 6+ cycles -> lvl2 falls 5 edges after the first low sample, no pulse.
- btn1_raw and btn2_raw rise on the same edge -> P1 and P2 pulse in the same cycle; lvl1=lvl2=1.
- Pull reset low 2 cycles after btn1_raw rises (FSM in ARM), hold reset 1 cycle, keep btn1_raw=1 -> no pulse before reset; exactly one P1 pulse 5 edges after the first post-reset sample.
- Press/release btn1, btn2, btn1 with 8-cycle holds and gaps -> P1, P2, P1 pulses in order, each one cycle wide. Count exactly 2 on P1 and 1 on P2.
